accumulator_full: RTL and testbench
===================================

Name: accumulator_full

Overview:
- 16-bit accumulating datapath for the accumulator-machine design.
- Samples the external I/O bus into an input register and adds it to a running accumulator every clock.
- Drives the accumulator contents onto the output bus.
- Top-level datapath block: single clock domain, no handshake; the surrounding system supplies one operand per cycle.

Parameters:
- WIDTH, 16, data width of IOIn, the input register, the accumulator and Output.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. reset=0 clears all state immediately; reset=1 is normal operation.
- IOIn  input  WIDTH  operand bus from the I/O side; sampled every rising edge while out of reset.
- Output  output  WIDTH  current accumulator value, driven combinationally from the accumulator register.

Behaviour:
- State:
  - IN_REG[WIDTH-1:0]: input register.
  - ACC[WIDTH-1:0]: accumulator.
  - No other state.
- Reset:
  - While reset=0, IN_REG=0 and ACC=0 regardless of CLK. Clearing takes effect asynchronously, without waiting for a clock edge.
  - Output therefore reads 0 during reset.
- Normal operation, on each rising CLK edge with reset=1:
  - IN_REG <= IOIn.
  - ACC <= ACC + IN_REG, using the IN_REG value from before the edge.
- Latency:
  - IOIn sampled at edge k is added into ACC at edge k+1.
  - The contribution is visible on Output immediately after edge k+1.
  - After reset release, the first edge only loads IN_REG, so ACC remains 0 (0 + 0).
- Arithmetic:
  - Unsigned modulo-2^WIDTH addition. The carry out is discarded: no saturation, no overflow flag.
  - Signed interpretation wraps identically, as two's complement.
- Output = ACC at all times. There is no enable; accumulation occurs every cycle while out of reset.
- Reset asserted mid-operation: both registers clear at once; the accumulated sum is lost.
- Reset release: synchronize externally if needed. The block takes no special action, and the first post-release edge behaves as a normal edge.
- IOIn changes between edges have no effect until sampled.
- X/undriven reset is undefined. Benches must drive reset to 0 before relying on outputs.

Test Plan:
- Reset clear: hold reset=0 for 3 cycles with IOIn=16'hFF00 -> Output=16'h0000 throughout. Assert reset=0 mid-cycle with ACC nonzero -> Output drops to 0 before the next edge.
- Constant accumulation with wrap: reset=0, then reset=1, IOIn=16'hFF00 held. Output after successive post-release edges: 0000, FF00, FE00, FD00, FC00 (FF00+FF00 wraps to FE00).
- Latency check: after reset release, IOIn=16'h0001 for one cycle, then 16'h0000. Output after edge1=0000, edge2=0001, edge3=0001 (held, since later inputs are zero).
- Varying input: IOIn sequence 0003, 0005, 0007 on consecutive edges -> Output after edges 2,3,4 = 0003, 0008, 000F.
- Full-scale wrap: IOIn=16'hFFFF held -> Output sequence 0000, FFFF, FFFE, FFFD.
- Reset mid-run: accumulate to 16'hFE00, pulse reset=0 for half a cycle, release with IOIn=16'h0010 -> Output 0 during the pulse. After release: 0000 at edge1, 0010 at edge2, 0020 at edge3.

Source files
------------

// File: rtl/accumulator_full.sv
// accumulator_full: 16-bit accumulating datapath.
// Every rising clock edge the I/O operand is sampled into an input register.
// The value held there from the previous edge is added into the accumulator,
// so an operand sampled at edge k shows up on Output just after edge k+1.
// The addition is modulo 2^WIDTH and the carry is dropped.
//
// Ports:
//   CLK     system clock; all state updates happen on its rising edge
//   reset   asynchronous active-low reset; clears both registers at once
//   IOIn    operand bus from the I/O side, sampled every edge
//   Output  accumulator contents, driven straight from the register
module accumulator_full #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] IOIn,
  output logic [WIDTH-1:0] Output
);

  logic [WIDTH-1:0] in_reg_q, in_reg_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  // The sum uses in_reg_q, the operand captured on the previous edge.
  // This gives the one-cycle input-register latency.
  always_comb begin
    in_reg_d = IOIn;
    acc_d    = acc_q + in_reg_q;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      in_reg_q <= '0;
      acc_q    <= '0;
    end else begin
      in_reg_q <= in_reg_d;
      acc_q    <= acc_d;
    end
  end

  assign Output = acc_q;

endmodule

// File: tb/tb_accumulator_full.sv
// tb_accumulator_full: scoreboard bench for accumulator_full.
// Stimulus runs on the falling edge. For each cycle it pushes the Output
// value expected after the next rising edge. The reference keeps the list of
// operands sampled since reset. After an edge, Output equals the sum of every
// sampled operand except the newest one, taken modulo 2^16.
// A separate monitor pops one expectation 1 ns after each rising edge and
// compares it with Output.
module tb_accumulator_full;

  logic        clk;
  logic        reset;
  logic [15:0] io_in;
  logic [15:0] out_bus;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [15:0] hist[$];
  int          edge_no = 0;

  accumulator_full #(
    .WIDTH(16)
  ) dut (
    .CLK   (clk),
    .reset (reset),
    .IOIn  (io_in),
    .Output(out_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sum of every operand sampled since reset except the most recent one,
  // which is still sitting in the input register.
  function automatic logic [15:0] model_out();
    longint s = 0;
    for (int i = 0; i + 1 < hist.size(); i++) s += longint'(hist[i]);
    return 16'(s);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (time %0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      edge_no++;
      if (exp_q.size() > 0) begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("acc_out", out_bus, e);
      end
    end
  end

  // One clock cycle: drive inputs at the falling edge and predict the result.
  task automatic cycle(input logic rst_v, input logic [15:0] v);
    reset = rst_v;
    io_in = v;
    if (!rst_v) hist.delete();
    else hist.push_back(v);
    exp_q.push_back(model_out());
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset in the middle of the low phase and expect an immediate clear.
  task automatic async_assert();
    #1 reset = 1'b0;
    hist.delete();
    #1 check("async_clear", out_bus, 16'h0000);
  endtask

  task automatic release_reset_with(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, v);
  endtask

  initial begin
    reset = 1'b0;
    io_in = 16'hFF00;
    #1 check("reset_state", out_bus, 16'h0000);
    @(negedge clk);

    // Held in reset with a nonzero operand present
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'hFF00);

    // Constant accumulation with wrap: 0000 FF00 FE00 FD00 FC00
    release_reset_with(16'hFF00, 5);

    // Mid-cycle reset with the accumulator nonzero
    async_assert();
    cycle(1'b0, 16'h0000);

    // Latency: 0001 for one cycle, then zeros
    cycle(1'b1, 16'h0001);
    cycle(1'b1, 16'h0000);
    cycle(1'b1, 16'h0000);

    // Varying input: 3, 5, 7, then 0
    cycle(1'b0, 16'h0000);
    cycle(1'b1, 16'h0003);
    cycle(1'b1, 16'h0005);
    cycle(1'b1, 16'h0007);
    cycle(1'b1, 16'h0000);

    // Full-scale wrap: 0000 FFFF FFFE FFFD
    cycle(1'b0, 16'h0000);
    release_reset_with(16'hFFFF, 4);

    // Reset mid-run at FE00, short pulse, restart with 0010
    cycle(1'b0, 16'h0000);
    release_reset_with(16'hFF00, 3);
    check("pre_pulse_value", out_bus, 16'hFE00);
    async_assert();
    #1 reset = 1'b1;
    release_reset_with(16'h0010, 3);

    // Randomized operands with occasional synchronous and mid-cycle resets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        async_assert();
        #1 reset = 1'b1;
      end
      cycle(($urandom_range(0, 24) != 0), 16'($urandom));
    end

    // Every expectation must have been consumed by the monitor
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
    $fatal(1, "watchdog expired");
  end

endmodule
